// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: write-back has zero-latency priority; multi-cycle results wait in a 2-entry FIFO.
// Optional starvation stall request is enabled by defining WB_ARB_STARVE_EN.
module wb_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        mc_valid_i,
  input  logic [4:0]  mc_rd_i,
  input  logic [31:0] mc_data_i,
  output logic        mc_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o,
  output logic        stall_req_o,
  output logic [1:0]  pend_cnt_o
);

  logic        valid_reg [2];
  logic [4:0]  rd_reg    [2];
  logic [31:0] data_reg  [2];
  logic [1:0]  cnt_reg;
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;

  logic        wb_req;
  logic        fifo_ne;
  logic        pop;
  logic        accept;
  logic        enq;
  logic [1:0]  slot_wr;
  logic [1:0]  slot_kill;

  assign wb_req     = wb_we_i && (wb_rd_i != 5'd0);
  assign fifo_ne    = (cnt_reg != 2'd0);
  assign mc_ready_o = rst_n && (cnt_reg != 2'd2);
  assign pop        = rst_n && !wb_req && fifo_ne;
  assign accept     = mc_valid_i && mc_ready_o;
  // A same-cycle write-back to the same register makes the older mc result dead on arrival.
  assign enq        = accept && (mc_rd_i != 5'd0) && !(wb_req && (mc_rd_i == wb_rd_i));
  assign pend_cnt_o = cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_wr[gi]   = enq && (wr_ptr_reg == 1'(gi));
      assign slot_kill[gi] = wb_req && (rd_reg[gi] == wb_rd_i);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        valid_reg[i] <= 1'b0;
        rd_reg[i]    <= 5'd0;
        data_reg[i]  <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slot_wr[i]) begin
          valid_reg[i] <= 1'b1;
          rd_reg[i]    <= mc_rd_i;
          data_reg[i]  <= mc_data_i;
        end else if (slot_kill[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg ^ pop;
      wr_ptr_reg <= wr_ptr_reg ^ enq;
      case ({enq, pop})
        2'b10:   cnt_reg <= cnt_reg + 2'd1;
        2'b01:   cnt_reg <= cnt_reg - 2'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  always_comb begin
    rf_we_o   = 1'b0;
    rf_rd_o   = 5'd0;
    rf_data_o = 32'd0;
    if (rst_n && wb_req) begin
      rf_we_o   = 1'b1;
      rf_rd_o   = wb_rd_i;
      rf_data_o = wb_data_i;
    end else if (pop) begin
      // A killed head still drains its slot, just without a write strobe.
      rf_we_o   = valid_reg[rd_ptr_reg];
      rf_rd_o   = rd_reg[rd_ptr_reg];
      rf_data_o = data_reg[rd_ptr_reg];
    end
  end

`ifdef WB_ARB_STARVE_EN
  logic [3:0] starve_reg;
  logic       stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= 4'd0;
      stall_reg  <= 1'b0;
    end else if (pop || !fifo_ne) begin
      starve_reg <= 4'd0;
      if (pop) stall_reg <= 1'b0;
    end else if (starve_reg != 4'(STARVE_LIMIT)) begin
      starve_reg <= starve_reg + 4'd1;
      if (starve_reg + 4'd1 == 4'(STARVE_LIMIT)) stall_reg <= 1'b1;
    end
  end

  assign stall_req_o = stall_reg;
`else
  assign stall_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, reset/starvation sequences, and random traffic
// checked against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        mc_valid = 1'b0;
  logic [4:0]  mc_rd = 5'd0;
  logic [31:0] mc_data = 32'd0;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        stall_req;
  logic [1:0]  pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wb_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .mc_valid_i(mc_valid), .mc_rd_i(mc_rd), .mc_data_i(mc_data),
    .mc_ready_o(mc_ready), .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_data_o(rf_data),
    .stall_req_o(stall_req), .pend_cnt_o(pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending entries plus a blocked-cycle tally.
  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  int   blocked = 0;
  bit   m_stall = 1'b0;

  typedef struct {
    logic        we;  logic [4:0] rd;  logic [31:0] d;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        e_we; logic [4:0] e_rd; logic [31:0] e_d;
    logic        e_rdy; logic [1:0] e_pend;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_we = we; wb_rd = rd; wb_data = d;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
  endtask

  task automatic model_update();
    bit req, pop, acc;
    req = wb_we && (wb_rd != 0);
    pop = !req && (q.size() > 0);
    acc = mc_valid && (q.size() < 2);
    if (q.size() > 0 && !pop) begin
      blocked++;
      if (STARVE_ON && blocked >= LIMIT) m_stall = 1'b1;
    end else begin
      blocked = 0;
    end
    if (pop) m_stall = 1'b0;
    if (req)
      foreach (q[i]) if (q[i].rd == wb_rd) q[i].v = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc && mc_rd != 0 && !(req && mc_rd == wb_rd))
      q.push_back('{v: 1'b1, rd: mc_rd, d: mc_data});
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic e_we; logic [4:0] e_rd; logic [31:0] e_d;
    e_we = 1'b0; e_rd = 5'd0; e_d = 32'd0;
    if (wb_we && wb_rd != 0) begin
      e_we = 1'b1; e_rd = wb_rd; e_d = wb_data;
    end else if (q.size() > 0) begin
      e_we = q[0].v; e_rd = q[0].rd; e_d = q[0].d;
    end
    chk({tag, ".rf_we"},   32'(rf_we),    32'(e_we));
    chk({tag, ".rf_rd"},   32'(rf_rd),    32'(e_rd));
    chk({tag, ".rf_data"}, rf_data,       e_d);
    chk({tag, ".ready"},   32'(mc_ready), 32'(q.size() < 2));
    chk({tag, ".pend"},    32'(pend_cnt), 32'(q.size()));
    chk({tag, ".stall"},   32'(stall_req), 32'(m_stall));
  endtask

  task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input string tag);
    drive(we, rd, d, mv, mrd, md);
    #1;
    check_model(tag);
    advance();
  endtask

  initial begin
    // Directed vectors starting right after reset release (FIFO empty).
    vecs[0]  = '{0, 0, 0,            1, 5, 32'hA5A5A5A5, 0, 0, 0,            1, 0};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,            1, 5, 32'hA5A5A5A5, 1, 1};
    vecs[2]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0};
    vecs[3]  = '{1, 7, 32'h77,       1, 3, 32'h33,       1, 7, 32'h77,       1, 0};
    vecs[4]  = '{1, 7, 32'h77,       1, 4, 32'h44,       1, 7, 32'h77,       1, 1};
    vecs[5]  = '{1, 7, 32'h77,       1, 6, 32'h66,       1, 7, 32'h77,       0, 2};
    vecs[6]  = '{0, 0, 0,            0, 0, 0,            1, 3, 32'h33,       0, 2};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,            1, 4, 32'h44,       1, 1};
    vecs[8]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0};
    vecs[9]  = '{0, 0, 0,            1, 9, 32'h99,       0, 0, 0,            1, 0};
    vecs[10] = '{1, 9, 32'h11,       0, 0, 0,            1, 9, 32'h11,       1, 1};
    vecs[11] = '{0, 0, 0,            0, 0, 0,            0, 9, 32'h99,       1, 1};
    vecs[12] = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0};
    vecs[13] = '{0, 0, 0,            1, 12, 32'hC,       0, 0, 0,            1, 0};
    vecs[14] = '{1, 0, 32'hFF,       0, 0, 0,            1, 12, 32'hC,       1, 1};
    vecs[15] = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0};
    vecs[16] = '{1, 8, 32'h88,       1, 8, 32'h80,       1, 8, 32'h88,       1, 0};
    vecs[17] = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0};
    vecs[18] = '{0, 0, 0,            1, 0, 32'h5,        0, 0, 0,            1, 0};
    vecs[19] = '{0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0};

    // Reset state with a live write-back request on the inputs.
    drive(1, 5'd3, 32'hDEAD, 1, 5'd4, 32'hBEEF);
    repeat (3) @(negedge clk);
    chk("reset.ready", 32'(mc_ready), 0);
    chk("reset.rf_we", 32'(rf_we), 0);
    chk("reset.pend",  32'(pend_cnt), 0);
    chk("reset.stall", 32'(stall_req), 0);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].we, vecs[i].rd, vecs[i].d, vecs[i].mv, vecs[i].mrd, vecs[i].md);
      #1;
      chk($sformatf("vec%0d.rf_we", i),   32'(rf_we),    32'(vecs[i].e_we));
      chk($sformatf("vec%0d.rf_rd", i),   32'(rf_rd),    32'(vecs[i].e_rd));
      chk($sformatf("vec%0d.rf_data", i), rf_data,       vecs[i].e_d);
      chk($sformatf("vec%0d.ready", i),   32'(mc_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.pend", i),    32'(pend_cnt), 32'(vecs[i].e_pend));
      chk($sformatf("vec%0d.stall", i),   32'(stall_req), 0);
      advance();
    end

    // Starvation: one entry held behind a continuously busy write-back.
    step(1, 5'd1, 32'h1, 1, 5'd2, 32'h22, "starve.acc");
    for (int k = 1; k <= 4; k++) begin
      step(1, 5'd1, 32'h1, 0, 0, 0, $sformatf("starve.blk%0d", k));
    end
    #1;
    chk("starve.set", 32'(stall_req), 32'(STARVE_ON));
    step(0, 0, 0, 0, 0, 0, "starve.pop");
    #1;
    chk("starve.clr", 32'(stall_req), 0);
    chk("starve.empty", 32'(pend_cnt), 0);

    // Asynchronous reset with two buffered entries.
    step(1, 5'd7, 32'h7, 1, 5'd3, 32'h333, "rst.fill0");
    step(1, 5'd7, 32'h7, 1, 5'd4, 32'h444, "rst.fill1");
    chk("rst.full", 32'(pend_cnt), 2);
    drive(1, 5'd3, 32'hABC, 1, 5'd6, 32'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.async_pend",  32'(pend_cnt), 0);
    chk("rst.async_ready", 32'(mc_ready), 0);
    chk("rst.async_we",    32'(rf_we), 0);
    q.delete();
    blocked = 0;
    m_stall = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("rst.first_ready", 32'(mc_ready), 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, $sformatf("rst.drain%0d", k));
    end

    // Random traffic on a small register range to force kills and drops.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
           $sformatf("rnd%0d", n));
    end
    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0, 0, $sformatf("tail%0d", n));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets the consecutive blocked cycles before a stall request (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 wb_we_i  input  1  write-back stage register-write enable.
REQ-005 wb_rd_i  input  5  write-back destination register.
REQ-006 wb_data_i  input  32  write-back result value.
REQ-007 mc_valid_i  input  1  multi-cycle unit has a result.
REQ-008 mc_rd_i  input  5  multi-cycle destination register.
REQ-009 mc_data_i  input  32  multi-cycle result value.
REQ-010 mc_ready_o  output  1  arbiter accepts the multi-cycle result this cycle.
REQ-011 rf_we_o  output  1  register-file write enable.
REQ-012 rf_rd_o  output  5  register-file write address.
REQ-013 rf_data_o  output  32  register-file write data.
REQ-014 stall_req_o  output  1  registered request to stall the pipeline.
REQ-015 pend_cnt_o  output  2  number of buffered multi-cycle entries (0..2).

Function
REQ-016 The block shall share the single register-file write port between the write-back stage and the multi-cycle unit.
REQ-017 The block shall hold multi-cycle results in a 2-entry FIFO, where each entry is {valid, rd, data}.
REQ-018 mc_ready_o shall be 1 only when pend_cnt_o < 2, based on the registered count, with no same-cycle reuse of a slot freed by a pop.
REQ-019 An accept (mc_valid_i & mc_ready_o) shall enqueue the entry at the next edge; an accept with mc_rd_i==0 shall be consumed but not enqueued.
REQ-020 A write-back request shall be present when wb_we_i==1 and wb_rd_i!=0; a request to x0 shall be treated as idle.
REQ-021 The write-back path shall have fixed priority and zero latency: when requesting, rf_we_o/rf_rd_o/rf_data_o shall equal 1/wb_rd_i/wb_data_i combinationally in the same cycle.
REQ-022 When write-back is idle and the FIFO is non-empty, the head entry shall be popped.
REQ-023 For that pop, rf_we_o shall equal the head entry's valid bit, with rf_rd_o/rf_data_o taken from the head entry.
REQ-024 When there is no grant, rf_we_o shall be 0, and rf_rd_o/rf_data_o shall be 0.
REQ-025 A multi-cycle write shall reach the register file no earlier than 1 cycle after its accept.
REQ-026 Multi-cycle results are always older than a concurrent write-back write.
REQ-027 On a granted write-back to register X, every buffered entry with rd==X shall have its valid bit cleared (killed).
REQ-028 On a granted write-back to register X, an entry accepted in the same cycle with mc_rd_i==X shall be dropped.
REQ-029 A killed entry shall still occupy its slot until popped.
REQ-030 Simultaneous accept and pop shall leave pend_cnt_o unchanged, and FIFO order shall be preserved.
REQ-031 The starvation counter shall increment each cycle in which the FIFO is non-empty and no pop occurs.
REQ-032 The starvation counter shall clear on a pop or when the FIFO is empty.
REQ-033 stall_req_o shall be set at the edge where the starvation counter reaches STARVE_LIMIT, and cleared at the edge following the next pop.

Reset
REQ-034 While rst_n==0, the block shall force: FIFO empty, all valid bits 0, starvation counter 0, stall_req_o 0, pend_cnt_o 0.
REQ-035 While rst_n==0, mc_ready_o shall be 0 and rf_we_o shall be 0, regardless of inputs.
REQ-036 Reset asserted mid-operation shall discard buffered entries without writing them.
REQ-037 After rst_n rises, mc_ready_o shall be 1 in the first cycle.

Configuration
REQ-038 Macro WB_ARB_STARVE_EN shall control the starvation feature.
REQ-039 With WB_ARB_STARVE_EN defined, the counter and stall_req_o shall behave per REQ-031..REQ-033.
REQ-040 Without WB_ARB_STARVE_EN, the counter logic shall be absent, stall_req_o shall be constant 0, and STARVE_LIMIT shall be ignored.

Verification
REQ-041 Write-back idle; accept mc rd=5 data=0xA5A5A5A5 -> next cycle rf_we_o=1, rf_rd_o=5, rf_data_o=0xA5A5A5A5; pend_cnt_o goes 1->0.
REQ-042 Write-back writes rd=7 every cycle; two mc accepts (rd=3, rd=4) -> pend_cnt_o=2, mc_ready_o=0; after write-back idles, rd=3 then rd=4 are written on consecutive cycles.
REQ-043 Buffered mc entry rd=9; write-back writes rd=9 data=0x11 -> rf_data_o=0x11; the later pop of that entry gives rf_we_o=0 and pend_cnt_o decrements.
REQ-044 With WB_ARB_STARVE_EN and STARVE_LIMIT=4, one entry buffered and write-back busy -> stall_req_o=1 after 4 blocked cycles; it clears the cycle after the pop.
REQ-045 With pend_cnt_o=2, assert rst_n=0 asynchronously -> pend_cnt_o=0, mc_ready_o=0, rf_we_o=0 immediately; after release, no buffered write ever appears.
REQ-046 Write-back with wb_we_i=1 and rd=0 while the FIFO holds one entry -> the FIFO entry is written in that cycle.
